// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: command codes, header
// field positions and loader state encodings.
package mips_pkg;

    localparam logic [1:0] CMD_LOAD_IM = 2'b00;
    localparam logic [1:0] CMD_LOAD_DM = 2'b01;
    localparam logic [1:0] CMD_START   = 2'b11;

    localparam int CMD_HI  = 31;
    localparam int CMD_LO  = 30;
    localparam int BASE_HI = 29;
    localparam int BASE_LO = 16;
    localparam int CNT_HI  = 13;
    localparam int CNT_LO  = 0;

    localparam int HDR_AW = 14;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t ST_IDLE = 2'd0;
    localparam loader_state_t ST_LOAD = 2'd1;
    localparam loader_state_t ST_RUN  = 2'd2;
    localparam loader_state_t ST_HALT = 2'd3;

endpackage

// File: rtl/mips_loader_run_timer.sv
// Saturating 16-bit run-cycle counter; expired flags the last budgeted
// cycle while counting.
module run_timer
    import mips_pkg::*;
#(
    parameter int MAX_RUN = 115
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] count,
    output logic        expired
);

    localparam logic [16:0] LAST = 17'(MAX_RUN - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign expired = en && ({1'b0, count} == LAST);

endmodule

// File: rtl/mips_loader.sv
// Program loader and run controller: parses a header/payload word stream into
// instruction/data memory writes, then runs the core until halt or budget.
module mips_loader
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IM_DEPTH = 1024,
    parameter int DM_DEPTH = 1024,
    parameter int MAX_RUN  = 115,
    parameter int IM_AW    = $clog2(IM_DEPTH),
    parameter int DM_AW    = $clog2(DM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_halt,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [15:0]       cycle_count
);

    // One extra address bit so base+i past the 14-bit space stays out of range
    localparam logic [HDR_AW:0] IM_LIM = (HDR_AW + 1)'(IM_DEPTH);
    localparam logic [HDR_AW:0] DM_LIM = (HDR_AW + 1)'(DM_DEPTH);

    loader_state_t     state;
    logic              target_dm;
    logic [HDR_AW:0]   addr;
    logic [HDR_AW-1:0] remain;
    logic              xfer;
    logic [1:0]        cmd;
    logic              start_acc;
    logic              run_en;
    logic              expired;

    assign in_ready  = !reset && ((state == ST_IDLE) || (state == ST_LOAD));
    assign xfer      = in_valid && in_ready;
    assign cmd       = in_data[CMD_HI:CMD_LO];
    assign start_acc = xfer && (state == ST_IDLE) && (cmd == CMD_START);
    assign run_en    = (state == ST_RUN);

    assign cpu_reset = (state != ST_RUN);
    assign running   = (state == ST_RUN);
    assign done      = (state == ST_HALT);

    run_timer #(
        .MAX_RUN(MAX_RUN)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (run_en),
        .clr    (start_acc),
        .count  (cycle_count),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            target_dm <= 1'b0;
            addr      <= '0;
            remain    <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            timeout   <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            dm_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if ((cmd == CMD_LOAD_IM) || (cmd == CMD_LOAD_DM)) begin
                            target_dm <= (cmd == CMD_LOAD_DM);
                            addr      <= {1'b0, in_data[BASE_HI:BASE_LO]};
                            remain    <= in_data[CNT_HI:CNT_LO];
                            state     <= ST_LOAD;
                        end else if (cmd == CMD_START) begin
                            state <= ST_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        // Out-of-range words are still consumed; only the strobe is withheld
                        if (target_dm) begin
                            if (addr < DM_LIM) begin
                                dm_we    <= 1'b1;
                                dm_addr  <= addr[DM_AW-1:0];
                                dm_wdata <= in_data;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            if (addr < IM_LIM) begin
                                im_we    <= 1'b1;
                                im_addr  <= addr[IM_AW-1:0];
                                im_wdata <= in_data;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        addr   <= addr + 1'b1;
                        remain <= remain - 1'b1;
                        if (remain == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    // A halt coinciding with budget exhaustion is reported as a halt
                    if (cpu_halt || expired) begin
                        state <= ST_HALT;
                        if (!cpu_halt) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_loader.sv
// Scoreboard bench for mips_loader: loads are modelled as expected memory
// writes queued at issue time and matched by an independent strobe monitor.
module tb_mips_loader;

    localparam int DATA_W   = 32;
    localparam int IM_DEPTH = 1024;
    localparam int DM_DEPTH = 1024;
    localparam int MAX_RUN  = 115;
    localparam int IM_AW    = $clog2(IM_DEPTH);
    localparam int DM_AW    = $clog2(DM_DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              cpu_halt = 1'b0;
    logic              in_ready;
    logic              im_we;
    logic [IM_AW-1:0]  im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              dm_we;
    logic [DM_AW-1:0]  dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              cpu_reset;
    logic              running;
    logic              done;
    logic              timeout;
    logic              err;
    logic [15:0]       cycle_count;

    mips_loader #(
        .DATA_W  (DATA_W),
        .IM_DEPTH(IM_DEPTH),
        .DM_DEPTH(DM_DEPTH),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_halt   (cpu_halt),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .err        (err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dm;
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    bit          exp_err = 1'b0;
    logic [31:0] mon_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Strobe monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && (im_we || dm_we)) begin
            if (im_we && dm_we) begin
                checks++;
                errors++;
                $display("FAIL dual_strobe actual=both required=one");
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%s@%0h required=none",
                         dm_we ? "dm" : "im", dm_we ? 32'(dm_addr) : 32'(im_addr));
            end else begin
                mon_e    = exp_q.pop_front();
                mon_addr = dm_we ? 32'(dm_addr) : 32'(im_addr);
                chk("wr_target", 32'(dm_we), 32'(mon_e.dm));
                chk("wr_addr", mon_addr, 32'(mon_e.addr));
                chk("wr_data", dm_we ? dm_wdata : im_wdata, mon_e.data);
            end
        end
    end

    function automatic logic [31:0] hdr(input logic [1:0] cmd, input int base, input int cntm1);
        logic [13:0] b;
        logic [13:0] c;
        b = base[13:0];
        c = cntm1[13:0];
        return {cmd, b, 2'b00, c};
    endfunction

    function automatic void model_write(input bit dm, input int a, input logic [31:0] w);
        int depth;
        depth = dm ? DM_DEPTH : IM_DEPTH;
        if (a < depth) exp_q.push_back('{dm: dm, addr: 15'(a), data: w});
        else exp_err = 1'b1;
    endfunction

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_bound actual=not_ready required=ready");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic do_load(input bit dm, input int base, input int cntm1, input bit fixed, input bit gaps);
        logic [31:0] w;
        send_word(hdr(dm ? 2'b01 : 2'b00, base, cntm1));
        for (int i = 0; i <= cntm1; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            w = fixed ? (32'hA000_0000 + 32'(i)) : $urandom;
            send_word(w);
            model_write(dm, base + i, w);
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        cpu_halt = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_flags", {28'd0, running, done, timeout, err}, 0);
        chk("rst_count", 32'(cycle_count), 0);
        chk("rst_strobes", {30'd0, im_we, dm_we}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);
    endtask

    task automatic do_run(input int halt_at, input string tag);
        int low;
        int expn;
        bit ended;
        low   = 0;
        ended = 1'b0;
        send_word(hdr(2'b11, 0, 0));
        for (int k = 1; k <= MAX_RUN + 20 && !ended; k++) begin
            cpu_halt = (k == halt_at);
            @(negedge clk);
            if (!cpu_reset) low++;
            if (k == 1) chk({tag, "_running"}, 32'(running), 1);
            if (k == 2) chk({tag, "_count_first"}, 32'(cycle_count), 1);
            @(posedge clk);
            #1;
            if (!running) ended = 1'b1;
        end
        cpu_halt = 1'b0;
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL %s_run_bound actual=still_running required=halted", tag);
        end
        expn = (halt_at > 0) ? halt_at : MAX_RUN;
        chk({tag, "_low_cycles"}, 32'(low), 32'(expn));
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
        chk({tag, "_timeout"}, 32'(timeout), (halt_at > 0) ? 32'd0 : 32'd1);
        chk({tag, "_count"}, 32'(cycle_count), 32'(expn));
        repeat (3) @(negedge clk);
        chk({tag, "_done_sticky"}, {29'd0, done, running, in_ready}, 32'h4);
        chk({tag, "_count_hold"}, 32'(cycle_count), 32'(expn));
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;

        pulse_reset();

        // Basic LOAD_IM with fixed payload, back-to-back
        do_load(1'b0, 0, 3, 1'b1, 1'b0);
        drain("load_im");

        // Randomized loads including gaps and occasional out-of-range bases
        for (int n = 0; n < 12; n++) begin
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 1100)),
                    int'($urandom_range(0, 7)), 1'b0, 1'b1);
        end
        drain("rand_load");

        // DM load straddling the top of memory
        pulse_reset();
        do_load(1'b1, 16'h3FE, 3, 1'b0, 1'b0);
        drain("dm_edge");
        chk("dm_edge_err_set", 32'(err), 1);

        // Near the top of the 14-bit address space: nothing may wrap into low memory
        pulse_reset();
        do_load(1'b0, 16'h3FFE, 3, 1'b0, 1'b0);
        drain("addr_top");

        // Reserved command
        pulse_reset();
        send_word(hdr(2'b10, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383))));
        exp_err = 1'b1;
        @(negedge clk);
        chk("rsvd_err", 32'(err), 1);
        chk("rsvd_idle", {29'd0, in_ready, running, cpu_reset}, 32'h5);
        do_load(1'b0, 5, 2, 1'b0, 1'b0);
        drain("after_rsvd");

        // Asynchronous reset in the middle of a LOAD
        pulse_reset();
        send_word(hdr(2'b10, 0, 0));
        exp_err = 1'b1;
        send_word(hdr(2'b00, 16, 3));
        w0 = $urandom;
        send_word(w0);
        model_write(1'b0, 16, w0);
        w1 = $urandom;
        send_word(w1);
        reset = 1'b1;
        #1;
        chk("midload_strobes", {30'd0, im_we, dm_we}, 0);
        chk("midload_flags", {28'd0, running, done, timeout, err}, 0);
        chk("midload_ctrl", {30'd0, cpu_reset, in_ready}, 32'h2);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 1'b0;
        do_load(1'b0, 16, 3, 1'b0, 1'b1);
        drain("after_midload");

        // Runs: budget timeout, halt at cycle 40, halt on last budget cycle, random halt
        pulse_reset();
        do_run(0, "run_timeout");
        pulse_reset();
        do_run(40, "run_halt40");
        pulse_reset();
        do_run(MAX_RUN, "run_halt_last");
        pulse_reset();
        do_run(int'($urandom_range(2, MAX_RUN - 1)), "run_halt_rand");

        pulse_reset();
        do_load(1'b1, 100, 4, 1'b0, 1'b1);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
